// File: rtl/apb_timer.sv
`default_nettype none
// apb_timer: APB down-counter timer with one-shot/periodic modes, sticky expiry flag and level IRQ.
// Optional macro APB_TIMER_PRESCALER_EN adds the programmable prescaler; without it the timer ticks every enabled cycle.
module apb_timer #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 32,
  parameter int PRE_W  = 16
) (
  input  logic        apb_clk,
  input  logic        apb_reset,
  input  logic [31:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        timer_irq
);

  localparam logic [ADDR_W-1:0] OFF_CTRL   = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] OFF_LOAD   = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] OFF_VALUE  = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] OFF_PRE    = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] OFF_STATUS = ADDR_W'(32'h10);

  logic [ADDR_W-1:0] offset;
  logic              access, bad, wr_en, rd_en;
  logic              hit_ctrl, hit_load, hit_value, hit_pre, hit_status;
  logic              en, periodic, irq_en, expired, irq_q;
  logic [CNT_W-1:0]  load, value;
  logic              tick, expire;
  logic [31:0]       rdata;
  logic              unused_paddr;

  assign offset     = PADDR[ADDR_W-1:0];
  assign access     = PSEL & PENABLE & ~apb_reset;
  assign hit_ctrl   = (offset == OFF_CTRL);
  assign hit_load   = (offset == OFF_LOAD);
  assign hit_value  = (offset == OFF_VALUE);
  assign hit_pre    = (offset == OFF_PRE);
  assign hit_status = (offset == OFF_STATUS);

  // Exact offset matching also rejects misaligned addresses.
  assign bad   = ~(hit_ctrl | hit_load | hit_value | hit_pre | hit_status) | (PWRITE & hit_value);
  assign wr_en = access & PWRITE & ~bad;
  assign rd_en = access & ~PWRITE & ~bad;

  assign unused_paddr = ^PADDR[31:ADDR_W];

`ifdef APB_TIMER_PRESCALER_EN
  logic [PRE_W-1:0] prescale, pcnt;

  assign tick = en & (pcnt == prescale);

  always_ff @(posedge apb_clk) begin
    if (apb_reset) begin
      prescale <= '0;
      pcnt     <= '0;
    end else begin
      if ((wr_en & hit_load) | (wr_en & hit_ctrl & PWDATA[0] & ~en))
        pcnt <= '0;
      else if (en)
        pcnt <= tick ? '0 : pcnt + PRE_W'(1);
      if (wr_en & hit_pre)
        prescale <= PWDATA[PRE_W-1:0];
    end
  end
`else
  logic [PRE_W-1:0] unused_pre;

  assign unused_pre = PWDATA[PRE_W-1:0];
  assign tick       = en;
`endif

  assign expire = tick & (value == '0);

  always_ff @(posedge apb_clk) begin
    if (apb_reset) begin
      en       <= 1'b0;
      periodic <= 1'b0;
      irq_en   <= 1'b0;
      load     <= '0;
      value    <= '0;
      expired  <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_en & hit_load)
        value <= PWDATA[CNT_W-1:0];
      else if (tick && value != '0)
        value <= value - CNT_W'(1);
      else if (expire && periodic)
        value <= load;

      if (wr_en & hit_load)
        load <= PWDATA[CNT_W-1:0];

      if (wr_en & hit_ctrl) begin
        en       <= PWDATA[0];
        periodic <= PWDATA[1];
        irq_en   <= PWDATA[2];
      end else if (expire & ~periodic) begin
        en <= 1'b0;
      end

      // A simultaneous expiry outranks the write-1-to-clear.
      if (expire)
        expired <= 1'b1;
      else if (wr_en & hit_status & PWDATA[0])
        expired <= 1'b0;

      irq_q <= expired & irq_en;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      if (hit_ctrl)
        rdata[2:0] = {irq_en, periodic, en};
      else if (hit_load)
        rdata[CNT_W-1:0] = load;
      else if (hit_value)
        rdata[CNT_W-1:0] = value;
      else if (hit_status)
        rdata[0] = expired;
`ifdef APB_TIMER_PRESCALER_EN
      else if (hit_pre)
        rdata[PRE_W-1:0] = prescale;
`endif
    end
  end

  assign PRDATA    = rdata;
  assign PREADY    = access;
  assign PSLVERR   = access & bad;
  assign timer_irq = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_timer.sv
`default_nettype none
// tb_apb_timer: randomized APB traffic against a cycle-level behavioural model of the timer.
module tb_apb_timer;

  logic        apb_clk = 1'b0;
  logic        apb_reset = 1'b1;
  logic [31:0] PADDR = '0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        timer_irq;

  int errors = 0;
  int checks = 0;
  bit mon_on = 1'b0;

  // Reference state of the timer.
  bit          m_en, m_per, m_ie, m_exp, m_irq;
  int unsigned m_load, m_value, m_pre, m_pcnt;

  apb_timer dut (
    .apb_clk  (apb_clk),
    .apb_reset(apb_reset),
    .PADDR    (PADDR),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .timer_irq(timer_irq)
  );

  always #5 apb_clk = ~apb_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_err(input int unsigned off, input bit wr);
    bit mapped;
    mapped = (off == 32'h0) || (off == 32'h4) || (off == 32'h8) || (off == 32'hC) || (off == 32'h10);
    return !mapped || (wr && off == 32'h8);
  endfunction

  function automatic int unsigned eff_prescale();
`ifdef APB_TIMER_PRESCALER_EN
    return m_pre;
`else
    return 0;
`endif
  endfunction

  function automatic int unsigned exp_read(input int unsigned off);
    case (off)
      32'h0:   return {29'd0, m_ie, m_per, m_en};
      32'h4:   return m_load;
      32'h8:   return m_value;
      32'hC:   return eff_prescale();
      32'h10:  return {31'd0, m_exp};
      default: return 0;
    endcase
  endfunction

  // Spec rules applied once per clock: timer tick first, then any legal write overrides.
  always @(posedge apb_clk) begin
    bit          wr, fire, expire, old_en;
    int unsigned off;
    if (apb_reset) begin
      m_en = 0; m_per = 0; m_ie = 0; m_exp = 0; m_irq = 0;
      m_load = 0; m_value = 0; m_pre = 0; m_pcnt = 0;
    end else begin
      off    = PADDR & 32'hFFF;
      wr     = PSEL && PENABLE && PWRITE && !is_err(off, 1'b1);
      old_en = m_en;
      fire   = m_en && (m_pcnt == eff_prescale());
      expire = fire && (m_value == 0);
      m_irq  = m_exp && m_ie;
      if (m_en) m_pcnt = fire ? 0 : m_pcnt + 1;
      if (fire) begin
        if (m_value != 0) m_value = m_value - 1;
        else begin
          m_exp = 1;
          if (m_per) m_value = m_load;
          else m_en = 0;
        end
      end
      if (wr) begin
        case (off)
          32'h0: begin
            if (!old_en && PWDATA[0]) m_pcnt = 0;
            m_en = PWDATA[0]; m_per = PWDATA[1]; m_ie = PWDATA[2];
          end
          32'h4: begin m_load = PWDATA; m_value = PWDATA; m_pcnt = 0; end
`ifdef APB_TIMER_PRESCALER_EN
          32'hC: m_pre = PWDATA & 32'hFFFF;
`endif
          32'h10: if (PWDATA[0] && !expire) m_exp = 0;
          default: ;
        endcase
      end
    end
  end

  always @(negedge apb_clk) begin
    if (mon_on) begin
      #1;
      chk("irq", {31'd0, timer_irq}, {31'd0, m_irq});
    end
  end

  task automatic xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output bit err);
    int unsigned off;
    off = addr & 32'hFFF;
    @(negedge apb_clk);
    PSEL = 1; PENABLE = 0; PADDR = addr; PWRITE = wr; PWDATA = wdata;
    #1;
    chk("pready_setup", {31'd0, PREADY}, 32'd0);
    @(negedge apb_clk);
    PENABLE = 1;
    #1;
    rdata = PRDATA;
    err   = PSLVERR;
    chk("pready", {31'd0, PREADY}, 32'd1);
    chk("pslverr", {31'd0, PSLVERR}, {31'd0, is_err(off, wr)});
    chk("prdata", PRDATA, (wr || is_err(off, wr)) ? 32'd0 : exp_read(off));
    @(negedge apb_clk);
    PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge apb_clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit          er;
    int unsigned offs[5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    int unsigned bads[5] = '{32'h14, 32'h6, 32'h11, 32'h1FC, 32'h2};

    idle(3);
    chk("irq_in_reset", {31'd0, timer_irq}, 32'd0);
    apb_reset = 0;
    mon_on = 1;

    foreach (offs[i]) begin
      xfer(offs[i], 0, 0, rd, er);
      chk("reset_read", rd, 32'd0);
    end

    // One-shot expiry.
    xfer(32'h4, 1, 2, rd, er);
    xfer(32'hC, 1, 0, rd, er);
    xfer(32'h0, 1, 1, rd, er);
    idle(6);
    xfer(32'h0, 0, 0, rd, er);  chk("oneshot_ctrl", rd, 32'd0);
    xfer(32'h8, 0, 0, rd, er);  chk("oneshot_value", rd, 32'd0);
    xfer(32'h10, 0, 0, rd, er); chk("oneshot_status", rd, 32'd1);
    xfer(32'h10, 1, 1, rd, er);

    // Periodic with prescaler and IRQ.
    xfer(32'h4, 1, 3, rd, er);
    xfer(32'hC, 1, 1, rd, er);
    xfer(32'h0, 1, 7, rd, er);
    repeat (10) xfer(32'h8, 0, 0, rd, er);
    xfer(32'h10, 0, 0, rd, er);

    // W1C colliding with an expiry every cycle, then a clean clear.
    xfer(32'hC, 1, 0, rd, er);
    xfer(32'h4, 1, 0, rd, er);
    xfer(32'h0, 1, 7, rd, er);
    idle(2);
    xfer(32'h10, 1, 1, rd, er);
    xfer(32'h10, 0, 0, rd, er); chk("w1c_collide", rd, 32'd1);
    xfer(32'h0, 1, 4, rd, er);
    idle(2);
    xfer(32'h10, 1, 1, rd, er);
    chk("irq_hold", {31'd0, timer_irq}, 32'd1);
    @(negedge apb_clk); #1;
    chk("irq_drop", {31'd0, timer_irq}, 32'd0);
    xfer(32'h10, 0, 0, rd, er); chk("status_cleared", rd, 32'd0);

    // Illegal accesses.
    xfer(32'h4, 1, 32'h55, rd, er);
    xfer(32'h14, 0, 0, rd, er);          chk("err_unmapped", {31'd0, er}, 32'd1);
    xfer(32'h8, 1, 32'hDEADBEEF, rd, er); chk("err_wr_value", {31'd0, er}, 32'd1);
    xfer(32'h6, 0, 0, rd, er);           chk("err_misalign", {31'd0, er}, 32'd1);
    xfer(32'h8, 0, 0, rd, er);           chk("value_kept", rd, 32'h55);

    // PRESCALE write/readback follows the build option.
    xfer(32'hC, 1, 5, rd, er);           chk("pre_wr_ok", {31'd0, er}, 32'd0);
    xfer(32'hC, 0, 0, rd, er);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] hi;
      hi = ($urandom_range(0, 3) == 0) ? ($urandom << 12) : 32'd0;
      case ($urandom_range(0, 7))
        0: xfer(hi | 32'h4, 1, $urandom_range(0, 6), rd, er);
        1: xfer(hi | 32'hC, 1, $urandom_range(0, 3), rd, er);
        2: xfer(hi | 32'h0, 1, $urandom_range(0, 7), rd, er);
        3: xfer(hi | 32'h10, 1, $urandom_range(0, 1), rd, er);
        4, 5: xfer(hi | offs[$urandom_range(0, 4)], 0, 0, rd, er);
        6: xfer(hi | bads[$urandom_range(0, 4)], $urandom_range(0, 1), $urandom, rd, er);
        default: idle($urandom_range(1, 5));
      endcase
    end

    // Reset in the middle of a count.
    xfer(32'h4, 1, 32'h10, rd, er);
    xfer(32'h0, 1, 32'h5, rd, er);
    idle(2);
    @(negedge apb_clk);
    apb_reset = 1;
    @(negedge apb_clk);
    apb_reset = 0;
    #1;
    chk("irq_after_reset", {31'd0, timer_irq}, 32'd0);
    foreach (offs[i]) begin
      xfer(offs[i], 0, 0, rd, er);
      chk("post_reset_read", rd, 32'd0);
    end

    mon_on = 0;
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_timer.md
Name: apb_timer

Overview:
- APB slave peripheral that sits directly downstream of the AHB-to-APB bridge in the 0x0020_0000–0x00FF_FFFF peripheral window; it consumes the bridge's PSEL/PENABLE/PADDR/PWRITE/PWDATA transfers.
- 32-bit down-counter with programmable prescaler, one-shot or periodic mode, sticky expiry flag and level interrupt.
- Zero-wait-state register access; error response on unmapped or illegal accesses.

Parameters:
ADDR_W, 12, number of low PADDR bits decoded (block occupies a 4 KB window)
CNT_W, 32, width of LOAD/VALUE counter
PRE_W, 16, width of prescaler

Ports:
apb_clk  in  1  APB clock, rising-edge
apb_reset  in  1  synchronous active-high reset
PADDR  in  32  APB address; only [ADDR_W-1:0] decoded
PSEL  in  1  slave select
PENABLE  in  1  access phase
PWRITE  in  1  1 = write
PWDATA  in  32  write data
PRDATA  out  32  read data
PREADY  out  1  transfer complete
PSLVERR  out  1  error response
timer_irq  out  1  level interrupt, active-high

Behaviour:
- Register map (byte offsets, word aligned):
  - 0x00 CTRL RW: [0] EN, [1] PERIODIC, [2] IRQ_EN; other bits read 0.
  - 0x04 LOAD RW.
  - 0x08 VALUE RO.
  - 0x0C PRESCALE RW [PRE_W-1:0].
  - 0x10 STATUS: [0] EXPIRED, write-1-to-clear.
- Access phase = PSEL & PENABLE. PREADY = 1 whenever PSEL & PENABLE, else 0; no wait states.
- PRDATA = selected register during read access phase, else 32'h0.
- PSLVERR = 1 during access phase if any of:
  - offset not in map;
  - PADDR[1:0] != 0;
  - write to VALUE.
  - An erroring write changes no state.
- Writes commit on the apb_clk edge ending the access phase.
- Reset (sync, apb_reset=1 at clock edge): CTRL=0, LOAD=0, VALUE=0, PRESCALE=0, EXPIRED=0, prescale counter pcnt=0. Outputs: PRDATA=0, PREADY=0, PSLVERR=0, timer_irq=0.
- Prescaler: while EN=1, pcnt increments each cycle. When pcnt==PRESCALE, pcnt<=0 and a one-cycle tick is generated. EN=0 holds pcnt and VALUE.
- On tick:
  - VALUE!=0: VALUE<=VALUE-1.
  - VALUE==0: EXPIRED<=1; if PERIODIC then VALUE<=LOAD, else EN<=0.
  - Period = (LOAD+1)*(PRESCALE+1) cycles.
- Write LOAD: VALUE<=PWDATA and pcnt<=0 in the same edge.
- CTRL write with EN 0->1: pcnt<=0; VALUE unchanged.
- timer_irq = EXPIRED & IRQ_EN, registered; asserts 1 cycle after either term becomes true.
- Simultaneous events:
  - STATUS W1C in the same cycle as expiry: set wins, EXPIRED stays 1.
  - LOAD write in the same cycle as tick: write wins.
  - CTRL write clearing EN in the same cycle as a one-shot expiry: EN=0, EXPIRED=1.
- Wrap: VALUE never decrements below 0. LOAD=0 periodic gives an expiry every PRESCALE+1 cycles.
- Reset mid-transfer: all state returns to reset values; the bus sees PREADY=0 until the next access phase.

Optional Feature:
APB_TIMER_PRESCALER_EN
- Defined: prescaler as above.
- Undefined: no pcnt logic, a tick every enabled cycle, PRESCALE offset reads 0, and writes to it are accepted and ignored (PSLVERR=0).

Test Plan:
- Reset, then read all offsets 0x00–0x10 -> PRDATA=0, PREADY=1, PSLVERR=0 on each access phase; timer_irq=0.
- LOAD=3, PRESCALE=1, CTRL=0x7 (EN|PERIODIC|IRQ_EN) -> EXPIRED set after 8 cycles, then every 8 cycles; VALUE reads 3,3,2,2,1,1,0,0,3…; timer_irq asserts 1 cycle after EXPIRED.
- One-shot: LOAD=2, PRESCALE=0, CTRL=0x1 -> EXPIRED after 3 cycles, CTRL reads 0x0, VALUE holds 0.
- Write STATUS=1 in the same cycle a periodic expiry occurs -> EXPIRED remains 1; a later W1C with no expiry clears it and timer_irq drops 1 cycle later.
- Read offset 0x14, write offset 0x08 with 0xDEADBEEF, read offset 0x06 -> PSLVERR=1 on each; VALUE unchanged.
- Assert apb_reset mid-count (VALUE=0x10, EN=1) -> next cycle all registers 0 and timer_irq=0; with APB_TIMER_PRESCALER_EN undefined, PRESCALE=5 write then read returns 0 and period = LOAD+1.
